// File: rtl/stream_mux_pkg.sv
// Shared mode constants and sizing helper for the stream_mux_rr channel combiner.
// The optional packet lock is enabled by defining STREAM_MUX_LOCK_EN.
package stream_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first requester after ptr,
// wrapping modulo NUM_CH (NUM_CH need not be a power of two).
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    int              pos;
    logic [CH_W-1:0] c;

    // NOTE: combinational blocks use blocking '=' and give every output a default
    // first, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        c   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            // ptr is always below NUM_CH, so one conditional subtract is the modulo.
            pos = int'(ptr) + k;
            if (pos >= NUM_CH) begin
                pos = pos - NUM_CH;
            end
            c = CH_W'(pos);
            if (en && !any && req[c]) begin
                any    = 1'b1;
                idx    = c;
                gnt[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream combiner with a registered output stage and
// round-robin or fixed-select arbitration; STREAM_MUX_LOCK_EN adds packet lock.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 8,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [CH_W-1:0]         sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic              load;
    logic              xfer;
    logic              rr_en;
    logic [NUM_CH-1:0] rr_gnt;
    logic [CH_W-1:0]   rr_idx;
    logic              rr_any;

    logic              cand_valid;
    logic [CH_W-1:0]   cand_idx;
    logic [NUM_CH-1:0] cand_onehot;
    logic [WIDTH-1:0]  cand_data;
    logic              cand_last;

    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;
    logic              out_last_q,  out_last_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   ptr_q,       ptr_d;
`ifdef STREAM_MUX_LOCK_EN
    logic              lock_q,      lock_d;
    logic [CH_W-1:0]   lock_ch_q,   lock_ch_d;
`endif

`ifdef STREAM_MUX_LOCK_EN
    assign rr_en = (mode == MODE_RR) && !lock_q;
`else
    assign rr_en = (mode == MODE_RR);
`endif

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req (in_valid),
        .ptr (ptr_q),
        .en  (rr_en),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // A held packet overrides mode and sel; otherwise mode picks the source.
    always_comb begin
        cand_valid  = 1'b0;
        cand_idx    = '0;
        cand_onehot = '0;
`ifdef STREAM_MUX_LOCK_EN
        if (lock_q) begin
            cand_valid  = in_valid[lock_ch_q];
            cand_idx    = lock_ch_q;
            cand_onehot = NUM_CH'(1) << lock_ch_q;
        end else
`endif
        if (mode == MODE_FIXED) begin
            if (int'(sel) < NUM_CH) begin
                cand_valid  = in_valid[sel];
                cand_idx    = sel;
                cand_onehot = NUM_CH'(1) << sel;
            end
        end else begin
            cand_valid  = rr_any;
            cand_idx    = rr_idx;
            cand_onehot = rr_gnt;
        end
    end

    always_comb begin
        cand_data = '0;
        cand_last = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cand_idx == CH_W'(c)) begin
                cand_data = in_data[c*WIDTH +: WIDTH];
                cand_last = in_last[c];
            end
        end
    end

    assign load     = !out_valid_q || out_ready;
    assign xfer     = load && cand_valid;
    assign in_ready = (rst_n && xfer) ? cand_onehot : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = cand_valid;
            if (cand_valid) begin
                out_data_d = cand_data;
                out_ch_d   = cand_idx;
                out_last_d = cand_last;
                if (mode == MODE_RR) begin
                    ptr_d = cand_idx;
                end
            end
        end
`ifdef STREAM_MUX_LOCK_EN
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            lock_d = !cand_last;
            if (!cand_last) begin
                lock_ch_d = cand_idx;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ptr_q       <= CH_W'(NUM_CH - 1);
`ifdef STREAM_MUX_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr (4-channel main instance plus a 3-channel one).
// Lock expectations follow STREAM_MUX_LOCK_EN when the bench is built with it.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    typedef struct {
        logic [W-1:0] data;
        int           ch;
        logic         last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W-1:0]    din [N];
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid, in_last, in_ready;
    logic            mode;
    logic [CW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic [CW-1:0]   out_ch;
    logic            out_last, out_valid, out_ready;

    logic [W-1:0]    din3 [3];
    logic [3*W-1:0]  in_data3;
    logic [2:0]      in_valid3, in_last3, in_ready3;
    logic            mode3;
    logic [1:0]      sel3;
    logic [W-1:0]    out_data3;
    logic [1:0]      out_ch3;
    logic            out_last3, out_valid3, out_ready3;

    beat_t           sb [$];
    int              n_cmp = 0;
    int              n_err = 0;

    int              m_ptr;
    logic            m_valid;
    logic            m_lock;
    logic [CW-1:0]   m_lock_ch;

    always #5 clk = ~clk;

    assign in_data  = {din[3], din[2], din[1], din[0]};
    assign in_data3 = {din3[2], din3[1], din3[0]};

    stream_mux_rr #(.NUM_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.NUM_CH(3), .WIDTH(W)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3),
        .out_data(out_data3), .out_ch(out_ch3), .out_last(out_last3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    // Reference arbitration written straight from the behavioural description.
    function automatic int model_grant();
`ifdef STREAM_MUX_LOCK_EN
        if (m_lock) return in_valid[m_lock_ch] ? int'(m_lock_ch) : -1;
`endif
        if (mode == MODE_FIXED) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            logic [CW-1:0] ci;
            c  = (m_ptr + k) % N;
            ci = CW'(c);
            if (in_valid[ci]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = N - 1;
        m_valid = 1'b0;
        m_lock  = 1'b0;
        m_lock_ch = '0;
        sb.delete();
    endtask

    // Called just after a falling edge with inputs already driven; advances one cycle.
    task automatic cycle(input string tag, output int g);
        logic          load;
        logic [N-1:0]  exp_rdy;
        logic [CW-1:0] gi;
        beat_t         b;
        #1;
        load = !m_valid || out_ready;
        g = load ? model_grant() : -1;
        gi = CW'((g < 0) ? 0 : g);
        exp_rdy = (g >= 0) ? (N'(1) << gi) : '0;
        n_cmp++;
        if (in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL %s in_ready: got %b want %b", tag, in_ready, exp_rdy);
        end
        if (g >= 0) begin
            sb.push_back('{din[gi], g, in_last[gi]});
            if (mode == MODE_RR) m_ptr = g;
`ifdef STREAM_MUX_LOCK_EN
            m_lock = !in_last[gi];
            if (!in_last[gi]) m_lock_ch = gi;
`endif
        end
        if (load) m_valid = (g >= 0);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== m_valid) begin
            n_err++;
            $display("FAIL %s out_valid: got %b want %b", tag, out_valid, m_valid);
        end
        if (g >= 0 && sb.size() > 0) begin
            b = sb.pop_front();
            n_cmp++;
            if ({out_data, out_ch, out_last} !== {b.data, CW'(b.ch), b.last}) begin
                n_err++;
                $display("FAIL %s beat: got data=%h ch=%0d last=%b want data=%h ch=%0d last=%b",
                         tag, out_data, out_ch, out_last, b.data, b.ch, b.last);
            end
        end
    endtask

    task automatic expect_ch(input string tag, input int want);
        n_cmp++;
        if (out_valid !== 1'b1 || int'(out_ch) != want) begin
            n_err++;
            $display("FAIL %s out_ch: got %0d (valid %b) want %0d", tag, out_ch, out_valid, want);
        end
    endtask

    task automatic test_reset();
        int g;
        rst_n = 1'b0;
        for (int c = 0; c < N; c++) din[c] = 8'hA0 + W'(c);
        in_valid = '1; in_last = '1; mode = MODE_RR; sel = '0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) din3[c] = 8'hC0 + W'(c);
        in_valid3 = '0; in_last3 = '1; mode3 = MODE_FIXED; sel3 = '0; out_ready3 = 1'b1;
        #3;
        n_cmp++;
        if ({out_valid, out_data, out_ch, out_last} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b data=%h ch=%0d last=%b want all zero",
                     out_valid, out_data, out_ch, out_last);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== '0) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle("reset_first", g);
        expect_ch("reset_first_grant", 0);
    endtask

    task automatic test_rr_fairness();
        int g;
        for (int i = 0; i < 8; i++) begin
            cycle("rr", g);
            expect_ch("rr_order", (i + 1) % N);
            n_cmp++;
            if (out_data !== 8'hA0 + W'((i + 1) % N)) begin
                n_err++;
                $display("FAIL rr_data: got %h want %h", out_data, 8'hA0 + W'((i + 1) % N));
            end
        end
    endtask

    task automatic test_back_pressure();
        int g;
        cycle("bp_pre", g);
        cycle("bp_pre", g);
        expect_ch("bp_setup", 2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold", g);
            n_cmp++;
            if ({out_valid, out_data, out_ch, out_last} !== {1'b1, 8'hA2, 2'd2, 1'b1}) begin
                n_err++;
                $display("FAIL bp_stable: got valid=%b data=%h ch=%0d last=%b want 1 a2 2 1",
                         out_valid, out_data, out_ch, out_last);
            end
        end
        out_ready = 1'b1;
        cycle("bp_release", g);
        expect_ch("bp_release_next", 3);
    endtask

    task automatic test_fixed();
        int g;
        mode = MODE_FIXED; sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            cycle("fixed_sel2", g);
            expect_ch("fixed_sel2", 2);
        end
        sel = 2'd3;
        cycle("fixed_sel3", g);
        expect_ch("fixed_sel3", 3);
        mode = MODE_RR;
    endtask

    task automatic test_fixed_out_of_range();
        int g;
        in_valid = '0;
        in_valid3 = 3'b111; sel3 = 2'd1;
        cycle("n3_idle", g);
        n_cmp++;
        if ({out_valid3, out_ch3, out_data3} !== {1'b1, 2'd1, 8'hC1}) begin
            n_err++;
            $display("FAIL n3_sel1: got valid=%b ch=%0d data=%h want 1 1 c1", out_valid3, out_ch3, out_data3);
        end
        sel3 = 2'd3;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (in_ready3 !== 3'b000) begin
                n_err++;
                $display("FAIL n3_sel3_ready: got %b want 000", in_ready3);
            end
            cycle("n3_idle", g);
            n_cmp++;
            if (out_valid3 !== 1'b0) begin
                n_err++;
                $display("FAIL n3_sel3_valid: got %b want 0", out_valid3);
            end
        end
        in_valid3 = '0;
    endtask

    task automatic test_sparse();
        int g;
        in_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            cycle("sparse_ch3", g);
            expect_ch("sparse_ch3", 3);
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle("sparse_alt", g);
            expect_ch("sparse_alt", (i % 2 == 0) ? 1 : 3);
        end
    endtask

    task automatic test_lock();
        int g;
        int sent = 0;
        int exp_seq [5];
`ifdef STREAM_MUX_LOCK_EN
        exp_seq = '{1, 1, 1, 0, 0};
`else
        exp_seq = '{1, 0, 1, 0, 1};
`endif
        in_valid = 4'b0001; in_last = '1;
        cycle("lock_prep", g);
        expect_ch("lock_prep", 0);
        for (int i = 0; i < 5; i++) begin
            in_valid   = (sent < 3) ? 4'b0011 : 4'b0001;
            in_last[1] = (sent == 2);
            din[1]     = 8'hB0 + W'(sent);
            cycle("lock_pkt", g);
            if (g == 1) sent++;
            expect_ch("lock_seq", exp_seq[i]);
        end
        in_last = '1; din[1] = 8'hA1;
    endtask

    task automatic test_reset_mid_packet();
        int g;
        in_valid = '1; in_last = 4'b1101;
        cycle("mid_pre", g);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got valid=%b in_ready=%b want 0 0000", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle("mid_after", g);
        expect_ch("mid_first_grant", 0);
        in_last = '1;
        cycle("mid_after2", g);
        expect_ch("mid_second_grant", 1);
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_back_pressure();
        test_fixed();
        test_fixed_out_of_range();
        test_sparse();
        test_lock();
        test_reset_mid_packet();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
